// File: rtl/turret_uart_rx.sv
// 8N1 UART receiver for the turret RX pin: 16x oversampling, start/stop validation,
// and a small first-word-fall-through FIFO with sticky overrun and framing-error pulse.
`timescale 1ns/1ps
module turret_uart_rx #(
    parameter int CLK_DIV    = 65,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       SYSCLK,
    input  logic       NSYSRESET,
    input  logic       RX,
    input  logic       RD,
    output logic [7:0] DATA,
    output logic       VALID,
    output logic       FRAMING_ERR,
    output logic       OVERRUN,
    input  logic       OVR_CLR
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [7:0]       TICK_LAST = 8'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_IDLE
    } state_t;

    logic             r_rx_meta, r_rx_s, r_rx_prev;
    logic [7:0]       r_tick_cnt;
    logic [3:0]       r_sub_cnt;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    state_t           r_state, w_state_nxt;
    logic             r_framing_err, r_overrun;
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_tick, w_fall, w_cnt_clr, w_sub_clr, w_shift_en, w_push, w_ferr;
    logic w_pop, w_full, w_wr_en, w_ovr_set;

    // Synchroniser idles high so reset never looks like a start edge.
    // NOTE: all clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= RX;
            r_rx_s    <= r_rx_meta;
            r_rx_prev <= r_rx_s;
        end
    end

    assign w_tick = (r_tick_cnt == TICK_LAST);
    assign w_fall = r_rx_prev & ~r_rx_s;

    always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_sub_clr   = 1'b0;
        w_shift_en  = 1'b0;
        w_push      = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    w_state_nxt = S_START;
                    w_cnt_clr   = 1'b1;
                end
            end
            S_START: begin
                if (w_tick && r_sub_cnt == 4'd7) begin
                    if (r_rx_s) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_DATA;
                        w_sub_clr   = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (w_tick && r_sub_cnt == 4'd15) begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == 3'd7) w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_tick && r_sub_cnt == 4'd15) begin
                    if (r_rx_s) begin
                        w_push      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_ferr      = 1'b1;
                        w_state_nxt = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (r_rx_s) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Start edge realigns the oversample phase to the frame.
    always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            r_tick_cnt <= '0;
            r_sub_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
        end else begin
            if (w_cnt_clr || w_tick) r_tick_cnt <= '0;
            else                     r_tick_cnt <= r_tick_cnt + 8'd1;

            if (w_cnt_clr || w_sub_clr) r_sub_cnt <= '0;
            else if (w_tick)            r_sub_cnt <= r_sub_cnt + 4'd1;

            if (w_cnt_clr)       r_bit_cnt <= '0;
            else if (w_shift_en) r_bit_cnt <= r_bit_cnt + 3'd1;

            if (w_shift_en) r_shift <= {r_rx_s, r_shift[7:1]};
        end
    end

    assign w_pop     = RD & VALID;
    assign w_full    = (r_count == FULL_CNT);
    assign w_wr_en   = w_push & (~w_full | w_pop);
    assign w_ovr_set = w_push & w_full & ~w_pop;

    // NOTE: storage is reset so DATA reads a defined 8'h00 after reset.
    always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
        end else if (w_wr_en) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_framing_err <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)   r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            r_framing_err <= w_ferr;
            // A new overrun takes priority over a clear in the same cycle.
            if (w_ovr_set)    r_overrun <= 1'b1;
            else if (OVR_CLR) r_overrun <= 1'b0;
        end
    end

    assign DATA        = r_mem[r_rd_ptr];
    assign VALID       = (r_count != '0);
    assign FRAMING_ERR = r_framing_err;
    assign OVERRUN     = r_overrun;

endmodule

// File: tb/tb_turret_uart_rx.sv
// Scoreboard bench for turret_uart_rx: frames are driven on RX, expected bytes are
// queued as frames complete and compared as the FIFO is drained.
`timescale 1ns/1ps
module tb_turret_uart_rx;

    localparam int CLK_DIV    = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int BIT_CYC    = 16 * CLK_DIV;
    // Posedges from the RX start-bit drive until the push edge (sync + edge detect + 152 ticks).
    localparam int PUSH_EDGE  = 2 + CLK_DIV * (8 + 16 * 9);

    logic       SYSCLK = 1'b0;
    logic       NSYSRESET;
    logic       RX;
    logic       RD;
    logic       OVR_CLR;
    logic [7:0] DATA;
    logic       VALID;
    logic       FRAMING_ERR;
    logic       OVERRUN;

    int         n_checks = 0;
    int         n_errors = 0;
    int         ferr_cnt = 0;
    int         f0;
    logic [7:0] exp_q[$];
    logic       exp_ovr = 1'b0;

    turret_uart_rx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .SYSCLK      (SYSCLK),
        .NSYSRESET   (NSYSRESET),
        .RX          (RX),
        .RD          (RD),
        .DATA        (DATA),
        .VALID       (VALID),
        .FRAMING_ERR (FRAMING_ERR),
        .OVERRUN     (OVERRUN),
        .OVR_CLR     (OVR_CLR)
    );

    always #5 SYSCLK = ~SYSCLK;

    always @(negedge SYSCLK) if (FRAMING_ERR) ferr_cnt++;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called and returns at a negedge; the model is updated once the frame is complete.
    task automatic send_frame(input logic [7:0] b, input logic stop_val,
                              input int stop_cyc, input bit model_it);
        RX = 1'b0;
        repeat (BIT_CYC) @(negedge SYSCLK);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (BIT_CYC) @(negedge SYSCLK);
        end
        RX = stop_val;
        repeat (stop_cyc) @(negedge SYSCLK);
        RX = 1'b1;
        if (model_it && stop_val) begin
            if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(b);
            else                           exp_ovr = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b1, BIT_CYC, 1'b1);
    endtask

    task automatic read_byte(input string tag);
        logic [7:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        check({tag, " valid"}, int'(VALID), 1);
        check({tag, " data"}, int'(DATA), int'(e));
        RD = 1'b1;
        @(negedge SYSCLK);
        RD = 1'b0;
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        NSYSRESET = 1'b0;
        RX        = 1'b1;
        RD        = 1'b0;
        OVR_CLR   = 1'b0;
        repeat (3) @(negedge SYSCLK);
        check("rst valid", int'(VALID), 0);
        check("rst data", int'(DATA), 0);
        check("rst ferr", int'(FRAMING_ERR), 0);
        check("rst ovr", int'(OVERRUN), 0);
        NSYSRESET = 1'b1;
        repeat (4) @(negedge SYSCLK);

        // 1. single byte with exact push latency, then pop and an ignored empty pop
        fork
            send_byte(8'hA5);
            begin
                repeat (PUSH_EDGE) @(posedge SYSCLK);
                #1 check("t1 valid before push", int'(VALID), 0);
                @(posedge SYSCLK);
                #1 check("t1 valid after push", int'(VALID), 1);
                check("t1 data after push", int'(DATA), 'hA5);
            end
        join
        read_byte("t1 read");
        check("t1 valid after pop", int'(VALID), 0);
        RD = 1'b1;
        @(negedge SYSCLK);
        RD = 1'b0;
        @(negedge SYSCLK);
        check("t1 empty pop ignored", int'(VALID), 0);

        // 2. glitch shorter than half a bit
        f0 = ferr_cnt;
        RX = 1'b0;
        repeat (20) @(negedge SYSCLK);
        RX = 1'b1;
        repeat (2 * BIT_CYC) @(negedge SYSCLK);
        check("t2 no push", int'(VALID), 0);
        check("t2 no ferr", ferr_cnt - f0, 0);
        send_byte(8'hC3);
        read_byte("t2 after glitch");

        // 3. framing error with a held break, then a clean byte
        f0 = ferr_cnt;
        fork
            send_frame(8'h3C, 1'b0, 3 * BIT_CYC, 1'b1);
            begin
                repeat (PUSH_EDGE) @(posedge SYSCLK);
                #1 check("t3 ferr before", int'(FRAMING_ERR), 0);
                @(posedge SYSCLK);
                #1 check("t3 ferr pulse", int'(FRAMING_ERR), 1);
                @(posedge SYSCLK);
                #1 check("t3 ferr after", int'(FRAMING_ERR), 0);
            end
        join
        repeat (BIT_CYC) @(negedge SYSCLK);
        check("t3 no push", int'(VALID), 0);
        check("t3 ferr count", ferr_cnt - f0, 1);
        send_byte(8'h11);
        read_byte("t3 recover");

        // 4. overrun on the fifth back-to-back byte
        for (int v = 1; v <= 5; v++) begin
            send_byte(8'(v));
            check($sformatf("t4 ovr after %0d", v), int'(OVERRUN), int'(exp_ovr));
        end
        for (int v = 1; v <= 4; v++) read_byte($sformatf("t4 read %0d", v));
        check("t4 drained", int'(VALID), 0);
        check("t4 ovr sticky", int'(OVERRUN), 1);
        OVR_CLR = 1'b1;
        @(negedge SYSCLK);
        OVR_CLR = 1'b0;
        check("t4 ovr cleared", int'(OVERRUN), 0);
        exp_ovr = 1'b0;

        // 5. push into a full FIFO on the same cycle as a pop
        for (int v = 1; v <= 4; v++) send_byte(8'(v));
        fork
            send_byte(8'h05);
            begin
                repeat (PUSH_EDGE) @(posedge SYSCLK);
                @(negedge SYSCLK);
                read_byte("t5 pop on push");
            end
        join
        check("t5 no ovr", int'(OVERRUN), 0);
        for (int v = 2; v <= 5; v++) read_byte($sformatf("t5 read %0d", v));
        check("t5 drained", int'(VALID), 0);

        // 6. reset during bit 3 of 8'hFF with a byte pending in the FIFO
        send_byte(8'h77);
        check("t6 pending", int'(VALID), 1);
        f0 = ferr_cnt;
        fork
            send_frame(8'hFF, 1'b1, BIT_CYC, 1'b0);
            begin
                repeat (4 * BIT_CYC + 40) @(negedge SYSCLK);
                NSYSRESET = 1'b0;
                exp_q.delete();
                exp_ovr = 1'b0;
                #1;
                check("t6 rst valid", int'(VALID), 0);
                check("t6 rst data", int'(DATA), 0);
                check("t6 rst ferr", int'(FRAMING_ERR), 0);
                check("t6 rst ovr", int'(OVERRUN), 0);
                repeat (3) @(negedge SYSCLK);
                NSYSRESET = 1'b1;
            end
        join
        repeat (2 * BIT_CYC) @(negedge SYSCLK);
        check("t6 no partial frame", int'(VALID), 0);
        check("t6 no ferr", ferr_cnt - f0, 0);
        send_byte(8'h5A);
        read_byte("t6 next byte");
        check("t6 drained", int'(VALID), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/turret_uart_rx.md
# turret_uart_rx

Fabric UART receiver for the turret controller's `RX` pin: the receive-side counterpart of the fabric `TX` path. It oversamples the serial line at 16× baud and decodes 8N1 frames. Received bytes go into a small first-word-fall-through FIFO that the fabric command logic drains. Framing errors and FIFO overruns are flagged so the command parser can drop corrupted aim/fire packets.

## Interface
Parameters:
- `CLK_DIV`, default 65: `SYSCLK` cycles per oversample tick. 10 MHz / (16 × 65) ≈ 9615 baud. Legal range 2..255.
- `FIFO_DEPTH`, default 4: FIFO entries, power of 2, 2..16.

Ports:
- `SYSCLK`  in  1: single system clock, 10 MHz nominal.
- `NSYSRESET`  in  1: asynchronous, active-low reset.
- `RX`  in  1: asynchronous serial input; idles high.
- `RD`  in  1: pop strobe. Honoured only when `VALID`=1.
- `DATA`  out  8: head-of-FIFO byte. Valid while `VALID`=1.
- `VALID`  out  1: FIFO not empty.
- `FRAMING_ERR`  out  1: one-cycle pulse when a bad stop bit is sampled.
- `OVERRUN`  out  1: sticky flag; a byte was dropped because the FIFO was full.
- `OVR_CLR`  in  1: synchronous clear of `OVERRUN`.

## Operation
- **Input synchroniser.** `RX` passes through a 2-flop synchroniser. Both flops reset to 1. All logic uses the synchronised signal `rx_s`.
- **Tick counter.** Counts 0..`CLK_DIV`-1. It emits `tick` on the terminal count, then wraps to 0. It is forced to 0 on start-edge detection so that sampling is aligned to the frame.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_IDLE. Reset state is IDLE.
  - IDLE: a falling edge on `rx_s` (previous 1, current 0) moves to START and clears the tick counter and the 4-bit sub-bit counter.
  - START: at the 8th tick (mid start bit):
    - `rx_s`=1 is a false start; return to IDLE.
    - `rx_s`=0 moves to DATA, with the sub-bit counter cleared.
  - DATA: every 16th tick, shift `rx_s` into the shift register LSB-first. After 8 bits, move to STOP.
  - STOP: at 16 ticks (mid stop bit):
    - `rx_s`=1: push the byte, then go to IDLE.
    - `rx_s`=0: pulse `FRAMING_ERR`, discard the byte, then go to WAIT_IDLE.
  - WAIT_IDLE: stay until `rx_s`=1, then go to IDLE. This prevents a break condition from being taken as repeated starts.
- **FIFO.** Circular buffer with read/write pointers and an occupancy count of width clog2(`FIFO_DEPTH`)+1.
  - `DATA` always shows the entry at the read pointer.
  - A pop on `RD`&`VALID` advances the read pointer.
  - `RD` while empty is ignored: no pointer change and no error.
  - A push when full with no pop in the same cycle drops the byte and sets `OVERRUN`.
  - A push and pop in the same cycle when full both take effect. Occupancy is unchanged and no overrun occurs.
  - A push and pop in the same cycle when empty is impossible, because a pop requires `VALID`.
  - `OVR_CLR` clears `OVERRUN`. If `OVR_CLR` and a new overrun occur in the same cycle, the set wins.
- **Reset values.** `VALID`=0, `FRAMING_ERR`=0, `OVERRUN`=0, `DATA`=8'h00. All FIFO storage, pointers, counters and the shift register are zero. FSM is in IDLE.
- **Reset mid-frame.** The partial byte is lost. After reset the receiver resumes only at the next falling edge, so a frame already in progress is not decoded.

## Timing
- Sync latency: 2 `SYSCLK` cycles from a pin edge to `rx_s`.
- Start detection fires 1 cycle after the `rx_s` transition.
- One bit time is 16 × `CLK_DIV` cycles. Bits are sampled at 8 + 16k ticks after the start edge, for k = 1..8 (data) and k = 9 (stop).
- Push occurs on the cycle of the stop-bit `tick`. `VALID` and `DATA` update on the next edge, for a total latency of 1 cycle.
- `FRAMING_ERR` is high for exactly one cycle, in the cycle after the stop-bit sample.
- Pop: `DATA`/`VALID` reflect the new head one cycle after the `RD` edge.
- Back-to-back frames are accepted with zero idle bits between them. The IDLE edge detector sees the stop→start transition.
- Tolerated baud mismatch: ±4%.

## Test plan
All scenarios use `CLK_DIV`=4 and `FIFO_DEPTH`=4, so one bit = 64 cycles.
1. **Single byte.** Send 8'hA5 in 8N1. `VALID` rises 1 cycle after the stop sample and `DATA`=8'hA5. Pulse `RD` → `VALID`=0 next cycle.
2. **Glitch.** Drive `RX` low for 20 cycles, then high → no push, no `FRAMING_ERR`, FSM back in IDLE.
3. **Framing error.** Send 8'h3C with stop bit 0, hold low for 2 bit times, then release → one-cycle `FRAMING_ERR` and `VALID` stays 0. Then send 8'h11 → `DATA`=8'h11.
4. **Overrun.** Send 8'h01..8'h05 back-to-back with no reads → `OVERRUN`=1 after the 5th byte. Reads return 01, 02, 03, 04, then `VALID`=0. `OVR_CLR` → `OVERRUN`=0.
5. **Full with simultaneous pop.** With the FIFO holding 01..04, assert `RD` on the push cycle of 8'h05 → `OVERRUN` stays 0. Reads return 02..05.
6. **Reset mid-frame.** Assert `NSYSRESET` low during bit 3 of 8'hFF → all outputs take their reset values. After release, the remainder of that frame produces nothing, and the next 8'h5A is received correctly.
